// File: rtl/isa_imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// isa_imem_loader_pkg
//
// Shared definitions for the instruction-memory loader:
//   - loader FSM state type (ST_IDLE, ST_EMIT)
//   - line geometry: lane count, lane width, line-address width
//   - derived widths for the line and for one FIFO entry (data + address)
//   - lane_sel: picks one 32-bit lane out of a 128-bit line
// ---------------------------------------------------------------------------
package isa_imem_loader_pkg;

    localparam int LANES   = 4;
    localparam int LANE_W  = 32;
    localparam int LINE_AW = 16;
    localparam int LINE_W  = LANES * LANE_W;
    localparam int ENTRY_W = LINE_W + LINE_AW;

    // Two-bit encoding leaves spare codes that the FSM folds back to idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EMIT = 2'b01
    } state_e;

    // Lane k of a line occupies bits [32k+31:32k].
    function automatic logic [LANE_W-1:0] lane_sel(
        input logic [LINE_W-1:0] line,
        input logic [1:0]        idx
    );
        logic [LANE_W-1:0] w;
        case (idx)
            2'd0:    w = line[0*LANE_W +: LANE_W];
            2'd1:    w = line[1*LANE_W +: LANE_W];
            2'd2:    w = line[2*LANE_W +: LANE_W];
            default: w = line[3*LANE_W +: LANE_W];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/isa_line_fifo.sv
// ---------------------------------------------------------------------------
// isa_line_fifo
//
// Synchronous register-array FIFO holding instruction lines (data + address).
// Binary read/write pointers carry one extra wrap bit so full and empty can
// be told apart without a separate counter. The caller guarantees that push
// is only asserted when there is room (or a pop happens on the same edge)
// and that pop is only asserted when the FIFO is non-empty.
//
// Ports:
//   clk_cpu  in   clock
//   rstn     in   asynchronous active-low reset; pointers return to 0
//   push_i   in   write wdata_i at the tail on this edge
//   wdata_i  in   WIDTH-bit entry
//   pop_i    in   drop the head entry on this edge
//   rdata_o  out  head entry (valid when empty_o=0)
//   full_o   out  FIFO holds DEPTH entries
//   empty_o  out  FIFO holds no entries
// ---------------------------------------------------------------------------
module isa_line_fifo #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 4
) (
    input  logic             clk_cpu,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q[PW-1:0]] = wdata_i;
            wr_ptr_d                = wr_ptr_q + (PW+1)'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_cpu or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Same slot index with opposite wrap bits means the writer lapped the reader.
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/isa_imem_loader.sv
// ---------------------------------------------------------------------------
// isa_imem_loader
//
// Consumer stage on the CPU clock side of the instruction-download path.
// Incoming 128-bit lines (with a 16-bit line address) are queued in a small
// FIFO and written to instruction memory as four 32-bit words through a
// ready-gated write port. Status outputs let the host see when a download
// has fully landed.
//
// Build option:
//   ISA_LOADER_BYTESWAP_EN  when defined, every 32-bit lane is byte-reversed
//                           before it reaches imem_wdata_o; otherwise lanes
//                           pass through unchanged.
//
// Ports:
//   clk_cpu       in   CPU clock
//   rstn          in   asynchronous active-low reset
//   isa_data_i    in   128-bit instruction line
//   isa_wren_i    in   one-cycle line-valid strobe (no backpressure)
//   isa_addr_i    in   16-bit line address
//   imem_we_o     out  instruction-memory write strobe
//   imem_addr_o   out  word address = {line_addr, lane}
//   imem_wdata_o  out  32-bit write data
//   imem_ready_i  in   memory accepts when imem_we_o && imem_ready_i
//   busy_o        out  a line is being written or lines are queued
//   overflow_o    out  sticky: a line was dropped because the FIFO was full
//   words_o       out  accepted-write counter, wraps at 16 bits
// ---------------------------------------------------------------------------
module isa_imem_loader
    import isa_imem_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int IMEM_AW    = 18
) (
    input  logic                 clk_cpu,
    input  logic                 rstn,
    input  logic [LINE_W-1:0]    isa_data_i,
    input  logic                 isa_wren_i,
    input  logic [LINE_AW-1:0]   isa_addr_i,
    output logic                 imem_we_o,
    output logic [IMEM_AW-1:0]   imem_addr_o,
    output logic [LANE_W-1:0]    imem_wdata_o,
    input  logic                 imem_ready_i,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [15:0]          words_o
);

    function automatic logic [LANE_W-1:0] swap_lane(input logic [LANE_W-1:0] w);
`ifdef ISA_LOADER_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [IMEM_AW-1:0] word_addr(
        input logic [LINE_AW-1:0] la,
        input logic [1:0]         lane
    );
        return IMEM_AW'({la, lane});
    endfunction

    state_e               state_q, state_d;
    logic [1:0]           lane_q, lane_d;
    logic [LINE_W-1:0]    line_q, line_d;
    logic [LINE_AW-1:0]   line_addr_q, line_addr_d;
    logic                 we_q, we_d;
    logic [IMEM_AW-1:0]   addr_q, addr_d;
    logic [LANE_W-1:0]    wdata_q, wdata_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          words_q, words_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic [LINE_W-1:0]    head_line;
    logic [LINE_AW-1:0]   head_addr;
    logic                 accept;
    logic                 load_head;
    logic [1:0]           next_lane;

    assign head_line = fifo_rdata[LINE_W-1:0];
    assign head_addr = fifo_rdata[ENTRY_W-1:LINE_W];

    isa_line_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_line_fifo (
        .clk_cpu (clk_cpu),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .wdata_i ({isa_addr_i, isa_data_i}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state logic for the write FSM. load_head marks the cases where the
    // FIFO head is popped straight into the output registers as lane 0; this
    // happens from idle and also on the last lane of a line so consecutive
    // lines stream without a gap.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        line_d      = line_q;
        line_addr_d = line_addr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        words_d     = words_q;
        load_head   = 1'b0;
        next_lane   = lane_q + 2'd1;
        accept      = we_q & imem_ready_i;

        if (accept) begin
            words_d = words_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                we_d = 1'b0;
                if (!fifo_empty) begin
                    load_head = 1'b1;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    if (lane_q != 2'd3) begin
                        lane_d  = next_lane;
                        addr_d  = word_addr(line_addr_q, next_lane);
                        wdata_d = swap_lane(lane_sel(line_q, next_lane));
                    end else if (!fifo_empty) begin
                        load_head = 1'b1;
                    end else begin
                        we_d    = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                we_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (load_head) begin
            line_d      = head_line;
            line_addr_d = head_addr;
            lane_d      = 2'd0;
            we_d        = 1'b1;
            addr_d      = word_addr(head_addr, 2'd0);
            wdata_d     = swap_lane(lane_sel(head_line, 2'd0));
            state_d     = ST_EMIT;
        end
    end

    // A full FIFO still takes a line when the head leaves on the same edge;
    // anything else arriving while full is lost and latched as overflow.
    always_comb begin
        fifo_pop   = load_head;
        fifo_push  = isa_wren_i & (~fifo_full | fifo_pop);
        overflow_d = overflow_q | (isa_wren_i & ~fifo_push);
    end

    // All state and memory-port outputs are registered here.
    always_ff @(posedge clk_cpu or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            lane_q      <= 2'd0;
            line_q      <= '0;
            line_addr_q <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            overflow_q  <= 1'b0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            line_q      <= line_d;
            line_addr_q <= line_addr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            overflow_q  <= overflow_d;
            words_q     <= words_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign overflow_o   = overflow_q;
    assign words_o      = words_q;
    assign busy_o       = (state_q == ST_EMIT) | ~fifo_empty;

endmodule
